// File: rtl/id_hazard_unit_pkg.sv
// Shared encodings and shadow-record type for the ID-stage hazard/forwarding controller.
package id_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EXALU  = 2'b01,
        FWD_MEMALU = 2'b10,
        FWD_MEMLD  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN = 2'b00,
        LU  = 2'b01,
        FRZ = 2'b10
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rw;
        logic       wreg;
        logic       m2reg;
    } shadow_t;

    // $0 is hardwired, so a write to it never produces a value worth forwarding
    function automatic logic is_live(input shadow_t e);
        return e.wreg && (e.rw != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_hazard_unit_if.sv
// ID-stage hazard bus: instruction fields in, stall/bubble/forwarding controls out.
interface id_hazard_unit_if #(parameter int unsigned CNT_W = 16);

    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic [4:0]       rw_id;
    logic             wreg_id;
    logic             m2reg_id;
    logic             flush;
    logic             hold;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, rw_id, wreg_id, m2reg_id, flush, hold,
        input  stall, bubble, fwda, fwdb, stall_cnt
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, rw_id, wreg_id, m2reg_id, flush, hold,
        output stall, bubble, fwda, fwdb, stall_cnt
    );

endinterface

// File: rtl/id_hazard_unit_hz_fwd_sel.sv
// Per-operand source match: picks the forwarding source and flags a load-use hit.
module hz_fwd_sel
    import id_hazard_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  shadow_t    ex,
    input  shadow_t    mem,
    output fwd_sel_e   fwd,
    output logic       lu_hit
);

    // A load in EX cannot supply data yet; the top masks fwd on a hit anyway
    always_comb begin
        fwd    = FWD_RF;
        lu_hit = 1'b0;
        if (use_src) begin
            if (is_live(ex) && (ex.rw == src)) begin
                if (ex.m2reg) lu_hit = 1'b1;
                else          fwd    = FWD_EXALU;
            end else if (is_live(mem) && (mem.rw == src)) begin
                fwd = mem.m2reg ? FWD_MEMLD : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/id_hazard_unit.sv
// Hazard/forwarding controller at the ID end of ID->EX: shadows EX/MEM destinations,
// produces stall, bubble and forwarding selects, and counts stall cycles.
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic              clock,
    input logic              reset,
    id_hazard_unit_if.slave  hz
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    shadow_t          ex_q;
    shadow_t          mem_q;
    shadow_t          id_entry;
    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    fwd_sel_e         sel_a;
    fwd_sel_e         sel_b;
    fwd_sel_e         fwda_c;
    fwd_sel_e         fwdb_c;
    logic             lu_a;
    logic             lu_b;
    logic             load_use;
    logic             stall_c;
    logic             bubble_c;

    always_comb begin
        id_entry       = '0;
        id_entry.rw    = hz.rw_id;
        id_entry.wreg  = hz.wreg_id;
        id_entry.m2reg = hz.m2reg_id;
    end

    hz_fwd_sel u_sel_a (
        .src     (hz.rs_id),
        .use_src (hz.use_rs_id),
        .ex      (ex_q),
        .mem     (mem_q),
        .fwd     (sel_a),
        .lu_hit  (lu_a)
    );

    hz_fwd_sel u_sel_b (
        .src     (hz.rt_id),
        .use_src (hz.use_rt_id),
        .ex      (ex_q),
        .mem     (mem_q),
        .fwd     (sel_b),
        .lu_hit  (lu_b)
    );

    assign load_use = lu_a | lu_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hz.hold) begin
            state_d = FRZ;
        end else begin
            unique case (state_q)
                RUN:     state_d = load_use ? LU : RUN;
                LU:      state_d = RUN;
                FRZ:     state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Priority hold > flush > load-use; selects are parked at FWD_RF on a load-use hit
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        fwda_c   = load_use ? FWD_RF : sel_a;
        fwdb_c   = load_use ? FWD_RF : sel_b;
        if (hz.hold) begin
            stall_c = 1'b1;
        end else if (hz.flush) begin
            bubble_c = 1'b1;
        end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!hz.hold) begin
            mem_q <= ex_q;
            ex_q  <= bubble_c ? '0 : id_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         cnt_q <= '0;
        else if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_ONE;
    end

    assign hz.stall     = stall_c;
    assign hz.bubble    = bubble_c;
    assign hz.fwda      = fwda_c;
    assign hz.fwdb      = fwdb_c;
    assign hz.stall_cnt = cnt_q;

endmodule
